ram_be_clr: RTL and testbench

Parametrised single-clock simple dual-port RAM. Successor to the team's basic video buffer RAM, adding:
- per-lane byte write enables
- read enable with a read-valid strobe
- selectable read latency (1 or 2)
- defined read-during-write behaviour
- a hardware clear engine that fills the whole array with a constant

Used for line and frame buffers in the video pipeline where a buffer must be blanked between frames.

---
 rtl/ram_be_clr.sv | 207 ++++++++++++++++++++
 tb/tb_ram_be_clr.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_be_clr.sv
// Simple dual-port RAM with lane write enables, 1/2-cycle read latency, defined read-during-write and a fill engine.
// Define RAM_PARITY_EN to store one even-parity bit per lane and flag mismatches on read.
module ram_be_clr #(
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  DATA_WIDTH = 16,
    parameter int                  LANE_WIDTH = 8,
    parameter int                  RD_LATENCY = 1,
    parameter int                  RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [ADDR_WIDTH-1:0]               waddr,
    input  logic [DATA_WIDTH-1:0]               wdata,
    input  logic                                we,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]    wbe,
    input  logic [ADDR_WIDTH-1:0]               raddr,
    input  logic                                re,
    output logic [DATA_WIDTH-1:0]               rdata,
    output logic                                rvalid,
    input  logic                                clr_req,
    output logic                                clr_busy,
    output logic                                parity_err
);

    localparam int LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("ram_be_clr: RD_LATENCY must be 1 or 2");
        end
        if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lanes
            $error("ram_be_clr: DATA_WIDTH must be a multiple of LANE_WIDTH");
        end
    endgenerate

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] clr_addr;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_err;
    logic                  rdw_hit;

    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_err;

    assign clr_busy = (state == S_CLEAR);
    assign clr_addr = cnt[ADDR_WIDTH-1:0];
    assign rd_acc   = re && !clr_busy;
    assign rdw_hit  = (RDW_MODE == 1) && we && !clr_busy && (waddr == raddr);

    // ---------------- clear engine ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (clr_req) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == (ADDR_WIDTH+1)'(DEPTH - 1)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ---------------- storage (not reset) ----------------
    always_ff @(posedge clk) begin
        if (clr_busy) begin
            mem[clr_addr] <= CLR_VALUE;
        end else if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (wbe[i]) begin
                    mem[waddr][i*LANE_WIDTH +: LANE_WIDTH] <= wdata[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic [LANES-1:0] mem_par [DEPTH];
    logic [LANES-1:0] rd_par;

    function automatic logic [LANES-1:0] lane_par(input logic [DATA_WIDTH-1:0] w);
        logic [LANES-1:0] p;
        for (int i = 0; i < LANES; i++) begin
            p[i] = ^w[i*LANE_WIDTH +: LANE_WIDTH];
        end
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (clr_busy) begin
            mem_par[clr_addr] <= lane_par(CLR_VALUE);
        end else if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (wbe[i]) begin
                    mem_par[waddr][i] <= ^wdata[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // Merged lanes take fresh parity so a same-address bypass never flags.
    always_comb begin
        rd_word = mem[raddr];
        rd_par  = mem_par[raddr];
        if (rdw_hit) begin
            for (int i = 0; i < LANES; i++) begin
                if (wbe[i]) begin
                    rd_word[i*LANE_WIDTH +: LANE_WIDTH] = wdata[i*LANE_WIDTH +: LANE_WIDTH];
                    rd_par[i] = ^wdata[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
        rd_err = |(rd_par ^ lane_par(rd_word));
    end
`else
    always_comb begin
        rd_word = mem[raddr];
        if (rdw_hit) begin
            for (int i = 0; i < LANES; i++) begin
                if (wbe[i]) begin
                    rd_word[i*LANE_WIDTH +: LANE_WIDTH] = wdata[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
        rd_err = 1'b0;
    end
`endif

    // ---------------- read pipeline ----------------
    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  p_valid;
            logic [DATA_WIDTH-1:0] p_data;
            logic                  p_err;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_valid <= 1'b0;
                    p_data  <= '0;
                    p_err   <= 1'b0;
                end else begin
                    p_valid <= rd_acc;
                    p_err   <= rd_acc && rd_err;
                    if (rd_acc) begin
                        p_data <= rd_word;
                    end
                end
            end

            assign s_valid = p_valid;
            assign s_data  = p_data;
            assign s_err   = p_err;
        end else begin : g_lat1
            assign s_valid = rd_acc;
            assign s_data  = rd_word;
            assign s_err   = rd_err;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata      <= '0;
            rvalid     <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            rvalid     <= s_valid;
            parity_err <= s_valid && s_err;
            if (s_valid) begin
                rdata <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_be_clr.sv
// Randomised and directed bench for ram_be_clr against an array/queue reference model.
module tb_ram_be_clr;

    localparam int   AW    = 4;
    localparam int   DW    = 16;
    localparam int   LW    = 8;
    localparam int   NL    = DW / LW;
    localparam int   DEPTH = 1 << AW;
    localparam int   LAT   = 2;
    localparam int   RDW   = 1;
    localparam logic [DW-1:0] CLRV = 16'h5A5A;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          we;
    logic [NL-1:0] wbe;
    logic [AW-1:0] raddr;
    logic          re;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          clr_req;
    logic          clr_busy;
    logic          parity_err;

    ram_be_clr #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW),
        .RD_LATENCY(LAT), .RDW_MODE(RDW), .CLR_VALUE(CLRV)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .waddr(waddr), .wdata(wdata), .we(we), .wbe(wbe),
        .raddr(raddr), .re(re),
        .rdata(rdata), .rvalid(rvalid),
        .clr_req(clr_req), .clr_busy(clr_busy),
        .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
        logic          perr;
    } rd_t;

    rd_t           q[$];
    logic [DW-1:0] mm [DEPTH];
    bit            bad [DEPTH];
    int            busy_left;
    int            cyc;
    logic [DW-1:0] exp_rdata;
    int            total;
    int            bad_cnt;
    int            busy_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs, advance the model by the rules, then check after the edge.
    task automatic step(input logic i_we, input logic [AW-1:0] i_wa, input logic [DW-1:0] i_wd,
                        input logic [NL-1:0] i_wbe, input logic i_re, input logic [AW-1:0] i_ra,
                        input logic i_clr);
        rd_t e;
        we = i_we; waddr = i_wa; wdata = i_wd; wbe = i_wbe;
        re = i_re; raddr = i_ra; clr_req = i_clr;
        if (busy_left == 0) begin
            if (i_re) begin
                e.d    = mm[i_ra];
                e.perr = bad[i_ra];
                if (RDW == 1 && i_we && i_wa == i_ra) begin
                    for (int l = 0; l < NL; l++)
                        if (i_wbe[l]) e.d[l*LW +: LW] = i_wd[l*LW +: LW];
                    if (i_wbe[0]) e.perr = 1'b0;
                end
                e.due = cyc + LAT;
                q.push_back(e);
            end
            if (i_we) begin
                for (int l = 0; l < NL; l++)
                    if (i_wbe[l]) mm[i_wa][l*LW +: LW] = i_wd[l*LW +: LW];
                if (i_wbe[0]) bad[i_wa] = 1'b0;
            end
            if (i_clr) busy_left = DEPTH;
        end else begin
            mm[DEPTH - busy_left]  = CLRV;
            bad[DEPTH - busy_left] = 1'b0;
            busy_left--;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rvalid_hi", 32'(rvalid), 32'd1);
            chk("rdata", 32'(rdata), 32'(q[0].d));
            chk("parity_err", 32'(parity_err), 32'(q[0].perr));
            exp_rdata = q[0].d;
            void'(q.pop_front());
        end else begin
            chk("rvalid_lo", 32'(rvalid), 32'd0);
            chk("rdata_hold", 32'(rdata), 32'(exp_rdata));
            chk("parity_err_lo", 32'(parity_err), 32'd0);
        end
        chk("clr_busy", 32'(clr_busy), 32'(busy_left > 0));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad_cnt = 0; cyc = 0; busy_left = 0; exp_rdata = '0;
        for (int a = 0; a < DEPTH; a++) begin mm[a] = '0; bad[a] = 1'b0; end
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wbe = '0;
        re = 1'b0; raddr = '0; clr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_busy", 32'(clr_busy), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        rst_n = 1'b1;

        // establish known contents
        step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        idle(DEPTH + 1);

        // lane enables
        step(1'b1, 4'd5, 16'hAAAA, 2'b11, 1'b0, '0, 1'b0);
        step(1'b1, 4'd5, 16'h1234, 2'b01, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0);
        idle(LAT);
        chk("be_merge", 32'(rdata), 32'h0000AA34);

        // back-to-back reads
        for (int a = 0; a < 4; a++) step(1'b1, 4'(a), 16'(16'h10 + a), 2'b11, 1'b0, '0, 1'b0);
        for (int a = 0; a < 4; a++) step(1'b0, '0, '0, '0, 1'b1, 4'(a), 1'b0);
        idle(LAT);
        chk("b2b_last", 32'(rdata), 32'h13);

        // read-during-write collision
        step(1'b1, 4'd7, 16'h00FF, 2'b11, 1'b0, '0, 1'b0);
        step(1'b1, 4'd7, 16'hAB00, 2'b10, 1'b1, 4'd7, 1'b0);
        idle(LAT);
        chk("rdw", 32'(rdata), (RDW == 1) ? 32'hABFF : 32'h00FF);

        // async reset with reads in flight; array must survive
        step(1'b1, 4'd9, 16'hC0DE, 2'b11, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd9, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0);
        we = 1'b0; re = 1'b0; clr_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rdata", 32'(rdata), 32'd0);
        chk("async_rvalid", 32'(rvalid), 32'd0);
        chk("async_busy", 32'(clr_busy), 32'd0);
        q.delete(); exp_rdata = '0; busy_left = 0;
        @(posedge clk);
        #1;
        cyc++;
        chk("rst_hold_rvalid", 32'(rvalid), 32'd0);
        rst_n = 1'b1;
        step(1'b0, '0, '0, '0, 1'b1, 4'd9, 1'b0);
        idle(LAT);
        chk("post_rst_data", 32'(rdata), 32'hC0DE);

        // clear with traffic and a second request while busy
        step(1'b1, 4'd2, 16'h1111, 2'b11, 1'b1, 4'd2, 1'b1);
        busy_seen = clr_busy ? 1 : 0;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 4'($urandom_range(0, DEPTH-1)), 16'($urandom), 2'b11,
                 1'b1, 4'($urandom_range(0, DEPTH-1)), (i == 5) ? 1'b1 : 1'b0);
            if (clr_busy) busy_seen++;
        end
        chk("clr_busy_len", 32'(busy_seen), 32'(DEPTH));
        for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, '0, 1'b1, 4'(a), 1'b0);
        idle(LAT);
        chk("clr_fill", 32'(rdata), 32'(CLRV));

        // clr_req held high across a whole clear
        for (int i = 0; i < DEPTH + 3; i++) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        idle(DEPTH + 2);

`ifdef RAM_PARITY_EN
        step(1'b1, 4'd3, 16'h0F0F, 2'b11, 1'b0, '0, 1'b0);
        dut.mem[3][0] = ~dut.mem[3][0];
        mm[3][0] = ~mm[3][0];
        bad[3] = 1'b1;
        step(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd4, 1'b0);
        idle(LAT);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, DEPTH-1)), 16'($urandom),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, DEPTH-1)), ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
        end
        idle(DEPTH + LAT + 2);

        $display("test done: total=%0d bad=%0d", total, bad_cnt);
        $finish;
    end

endmodule
